// File: rtl/vector_logic_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : vector_logic_pipe_if
// Purpose : Beat-input / result-output bundle for vector_logic_pipe.
//           The out_popcnt signal exists only when VLP_POPCOUNT_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
interface vector_logic_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int c_pc_w = $clog2(WIDTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_a;
    logic [WIDTH-1:0]      in_b;
    logic [2:0]            in_op;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_bitwise;
    logic                  out_logical;
    logic [2*WIDTH-1:0]    out_not;
    logic                  out_err;
`ifdef VLP_POPCOUNT_EN
    logic [c_pc_w-1:0]     out_popcnt;

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_bitwise, out_logical, out_not, out_err, out_popcnt
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_bitwise, out_logical, out_not, out_err, out_popcnt
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_bitwise, out_logical, out_not, out_err
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_bitwise, out_logical, out_not, out_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/vector_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vector_logic_pipe
// Purpose : Pipelined bitwise/logical vector operator with burst folding and
//           a DEPTH-entry result FIFO. Define VLP_POPCOUNT_EN to add out_popcnt.
// Revision: 1.0  initial release
// ============================================================================
module vector_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_logic_pipe_if.slave bus
);
    localparam int                 c_ptr_w     = $clog2(DEPTH);
    localparam int                 c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    localparam logic [2:0] c_op_or      = 3'd0;
    localparam logic [2:0] c_op_and     = 3'd1;
    localparam logic [2:0] c_op_xor     = 3'd2;
    localparam logic [2:0] c_op_pass    = 3'd3;
    localparam logic [2:0] c_op_acc_or  = 3'd4;
    localparam logic [2:0] c_op_acc_xor = 3'd5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_acc, w_acc_next;
    logic [2:0]         r_op, w_op_next;

    logic [2:0]         w_op;
    logic               w_in_ready, w_accept, w_is_burst, w_push, w_pop;
    logic [WIDTH-1:0]   w_acc_base, w_fold, w_bw;
    logic               w_lg, w_err;

    logic [WIDTH-1:0]   r_mem_bw  [DEPTH];
    logic               r_mem_lg  [DEPTH];
    logic [2*WIDTH-1:0] r_mem_not [DEPTH];
    logic               r_mem_err [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

`ifdef VLP_POPCOUNT_EN
    localparam int c_pc_w = $clog2(WIDTH + 1);

    logic [c_pc_w-1:0]  r_mem_pc [DEPTH];

    function automatic logic [c_pc_w-1:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [c_pc_w-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + c_pc_w'(v[i]);
        end
        return n;
    endfunction
`endif

    // Input stalls whenever the FIFO is full, including mid-burst beats.
    assign w_in_ready = rst_n && (r_count != c_depth_cnt);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = (r_count != '0) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_op    <= w_op_next;
        end
    end

    always_comb begin
        // Once inside a burst the latched opcode governs; in_op is ignored.
        w_op       = (r_state == ACCUM) ? r_op : bus.in_op;
        w_is_burst = (r_state == ACCUM) || (bus.in_op == c_op_acc_or) ||
                     (bus.in_op == c_op_acc_xor);
        w_acc_base = (r_state == ACCUM) ? r_acc : '0;
        w_fold     = (w_op == c_op_acc_xor) ? (w_acc_base ^ bus.in_a ^ bus.in_b)
                                            : (w_acc_base | bus.in_a | bus.in_b);

        w_bw  = bus.in_a | bus.in_b;
        w_lg  = (|bus.in_a) || (|bus.in_b);
        w_err = 1'b0;
        case (w_op)
            c_op_or: begin
                w_bw = bus.in_a | bus.in_b;
                w_lg = (|bus.in_a) || (|bus.in_b);
            end
            c_op_and: begin
                w_bw = bus.in_a & bus.in_b;
                w_lg = (|bus.in_a) && (|bus.in_b);
            end
            c_op_xor: begin
                w_bw = bus.in_a ^ bus.in_b;
                w_lg = (|bus.in_a) ^ (|bus.in_b);
            end
            c_op_pass: begin
                w_bw = bus.in_a;
                w_lg = |bus.in_a;
            end
            c_op_acc_or, c_op_acc_xor: begin
                w_bw = w_fold;
                w_lg = |w_fold;
            end
            default: w_err = 1'b1;
        endcase

        w_push       = w_accept && (!w_is_burst || bus.in_last);
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_op_next    = r_op;
        if (w_accept && w_is_burst) begin
            if (bus.in_last) begin
                w_state_next = IDLE;
                w_acc_next   = '0;
            end else begin
                w_state_next = ACCUM;
                w_acc_next   = w_fold;
                w_op_next    = w_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_bw[i]  <= '0;
                r_mem_lg[i]  <= 1'b0;
                r_mem_not[i] <= '0;
                r_mem_err[i] <= 1'b0;
`ifdef VLP_POPCOUNT_EN
                r_mem_pc[i]  <= '0;
`endif
            end
        end else begin
            if (w_push) begin
                r_mem_bw[r_wr_ptr]  <= w_bw;
                r_mem_lg[r_wr_ptr]  <= w_lg;
                r_mem_not[r_wr_ptr] <= {~bus.in_b, ~bus.in_a};
                r_mem_err[r_wr_ptr] <= w_err;
`ifdef VLP_POPCOUNT_EN
                r_mem_pc[r_wr_ptr]  <= f_popcount(w_bw);
`endif
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_count != '0);
    assign bus.out_bitwise = r_mem_bw[r_rd_ptr];
    assign bus.out_logical = r_mem_lg[r_rd_ptr];
    assign bus.out_not     = r_mem_not[r_rd_ptr];
    assign bus.out_err     = r_mem_err[r_rd_ptr];
`ifdef VLP_POPCOUNT_EN
    assign bus.out_popcnt  = r_mem_pc[r_rd_ptr];
`endif
endmodule
`default_nettype wire

// File: tb/tb_vector_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_logic_pipe
// Purpose : Self-checking bench for vector_logic_pipe (WIDTH=3, DEPTH=2).
// Revision: 1.0  initial release
// ============================================================================
module tb_vector_logic_pipe;
    localparam int W = 3;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vector_logic_pipe_if #(.WIDTH(W)) bus ();

    vector_logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
        logic [W-1:0] bw;
        logic         lg;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0]   bw;
        logic           lg;
        logic [2*W-1:0] nt;
        logic           err;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } beat_t;

    res_t       mq[$];
    beat_t      burst_beats[$];
    bit         in_burst = 0;
    logic [2:0] burst_op = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] bw, input logic lg,
                                 input logic [2*W-1:0] nt, input logic err);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_bw"},    bus.out_bitwise, bw);
        check({tag, "_lg"},    bus.out_logical, lg);
        check({tag, "_not"},   bus.out_not, nt);
        check({tag, "_err"},   bus.out_err, err);
`ifdef VLP_POPCOUNT_EN
        check({tag, "_pc"},    bus.out_popcnt, $countones(bw));
`endif
    endtask

    // Drive one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic last);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        #1 check("send_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Spec-level reference: results appear in acceptance order; a burst's result
    // is the fold of every beat it contained under the opcode of its first beat.
    task automatic model_beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic last);
        res_t  r;
        beat_t bt;
        logic [W-1:0] f;
        bt.a = a;
        bt.b = b;
        r.nt  = {~b, ~a};
        r.err = 1'b0;
        if (!in_burst && (op == 3'd4 || op == 3'd5)) begin
            burst_op = op;
            in_burst = 1;
            burst_beats.delete();
        end
        if (in_burst) begin
            burst_beats.push_back(bt);
            if (!last) return;
            f = '0;
            foreach (burst_beats[i])
                f = (burst_op == 3'd5) ? (f ^ burst_beats[i].a ^ burst_beats[i].b)
                                       : (f | burst_beats[i].a | burst_beats[i].b);
            r.bw = f;
            r.lg = (f != 0);
            in_burst = 0;
        end else begin
            case (op)
                3'd1: begin r.bw = a & b; r.lg = (a != 0) && (b != 0); end
                3'd2: begin r.bw = a ^ b; r.lg = (a != 0) != (b != 0); end
                3'd3: begin r.bw = a;     r.lg = (a != 0); end
                default: begin
                    r.bw  = a | b;
                    r.lg  = (a != 0) || (b != 0);
                    r.err = (op >= 3'd6);
                end
            endcase
        end
        mq.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[12];
        logic [W-1:0] bp_vals[3];
        logic [W-1:0] got[$];
        int           idx;
        logic         acc_now;

        tbl[0]  = '{3'd0, 3'b101, 3'b010, 1'b0, 3'b111, 1'b1, 1'b0};
        tbl[1]  = '{3'd1, 3'b110, 3'b011, 1'b0, 3'b010, 1'b1, 1'b0};
        tbl[2]  = '{3'd2, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{3'd2, 3'b101, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 3'b100, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0};
        tbl[5]  = '{3'd3, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{3'd1, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{3'd7, 3'b100, 3'b001, 1'b0, 3'b101, 1'b1, 1'b1};
        tbl[8]  = '{3'd6, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[9]  = '{3'd4, 3'b011, 3'b000, 1'b1, 3'b011, 1'b1, 1'b0};
        tbl[10] = '{3'd5, 3'b011, 3'b110, 1'b1, 3'b101, 1'b1, 1'b0};
        tbl[11] = '{3'd0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        bp_vals[0] = 3'b001;
        bp_vals[1] = 3'b010;
        bp_vals[2] = 3'b011;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready, 1'b0);
        check("rst_bw",        bus.out_bitwise, '0);
        check("rst_lg",        bus.out_logical, 1'b0);
        check("rst_not",       bus.out_not, '0);
        check("rst_err",       bus.out_err, 1'b0);
`ifdef VLP_POPCOUNT_EN
        check("rst_pc",        bus.out_popcnt, '0);
`endif
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Single-beat table, one result per beat with out_ready held high.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].last);
            check_outputs($sformatf("tbl%0d", i), tbl[i].bw, tbl[i].lg,
                          {~tbl[i].b, ~tbl[i].a}, tbl[i].err);
        end
        @(negedge clk);
        check("tbl_drain_valid", bus.out_valid, 1'b0);

        // XOR burst; the middle beat's opcode must be ignored.
        send(3'd5, 3'b001, 3'b000, 1'b0);
        check("burst_b1_valid", bus.out_valid, 1'b0);
        send(3'd0, 3'b010, 3'b000, 1'b0);
        check("burst_b2_valid", bus.out_valid, 1'b0);
        send(3'd3, 3'b100, 3'b001, 1'b1);
        check_outputs("burst", 3'b110, 1'b1, 6'b110011, 1'b0);
        @(negedge clk);
        check("burst_single_result", bus.out_valid, 1'b0);

        // Backpressure: FIFO fills after two accepts, then drains in order.
        bus.out_ready = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = (idx < 3);
            bus.in_a     = (idx < 3) ? bp_vals[idx] : '0;
            #1 acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc_now) idx++;
            @(negedge clk);
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready_full", bus.in_ready, 1'b0);
        check("bp_head_valid", bus.out_valid, 1'b1);
        check("bp_head_stable", bus.out_bitwise, bp_vals[0]);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) got.push_back(bus.out_bitwise);
            bus.in_valid = (idx < 3);
            bus.in_a     = (idx < 3) ? bp_vals[idx] : '0;
            #1 acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc_now) idx++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("bp_result_count", got.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : 'x, bp_vals[k]);
        check("bp_in_ready_again", bus.in_ready, 1'b1);

        // Reset mid-burst with one result queued discards everything.
        bus.out_ready = 1'b0;
        send(3'd0, 3'b001, 3'b010, 1'b0);
        send(3'd4, 3'b100, 3'b000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_bw",    bus.out_bitwise, '0);
        check("mid_rst_not",   bus.out_not, '0);
        check("mid_rst_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(3'd4, 3'b011, 3'b000, 1'b1);
        check_outputs("post_rst_acc", 3'b011, 1'b1, 6'b111100, 1'b0);
        @(negedge clk);
        check("post_rst_drain", bus.out_valid, 1'b0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            check("rnd_in_ready", bus.in_ready, (mq.size() < D));
            check("rnd_out_valid", bus.out_valid, (mq.size() != 0));
            if (mq.size() != 0 && bus.out_valid) begin
                check("rnd_bw",  bus.out_bitwise, mq[0].bw);
                check("rnd_lg",  bus.out_logical, mq[0].lg);
                check("rnd_not", bus.out_not, mq[0].nt);
                check("rnd_err", bus.out_err, mq[0].err);
`ifdef VLP_POPCOUNT_EN
                check("rnd_pc",  bus.out_popcnt, $countones(mq[0].bw));
`endif
            end
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_op     = 3'($urandom_range(7));
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.in_last   = ($urandom_range(2) == 0);
            bus.out_ready = ($urandom_range(2) != 0);
            @(posedge clk);
            acc_now = bus.in_valid && (mq.size() < D);
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            if (acc_now) model_beat(bus.in_op, bus.in_a, bus.in_b, bus.in_last);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
